// File: rtl/rom_fetch_ctrl.sv
`timescale 1ns/1ps
// Instruction fetch front end: walks a combinational ROM and buffers {pc, instr} pairs in a 2-deep prefetch FIFO.
// Latency: one cycle from a fetch into an empty buffer to instr_valid; redirect flushes and refetches next cycle.
// Backpressure: instr_valid/instr_ready handshake; fetching stalls when both entries are occupied and nothing pops.
module rom_fetch_ctrl #(
  parameter int          AWIDTH   = 8,
  parameter int          DWIDTH   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DWIDTH-1:0] instr,
  output logic [31:0]       instr_pc,
  output logic [1:0]        fifo_count
);

  typedef struct packed {
    logic [31:0]       pc;
    logic [DWIDTH-1:0] dat;
  } entry_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] fetch_pc;
  entry_t      head_ent;
  entry_t      tail_ent;
  entry_t      new_ent;
  logic [1:0]  count;
  logic        pop;
  logic        fetch;

  assign rom_addr    = fetch_pc[AWIDTH+1:2];
  assign new_ent     = '{pc: fetch_pc, dat: rom_rdata};
  assign instr_valid = (count != 2'd0) && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  assign fetch       = fetch_en && !redirect_valid && ((count < 2'd2) || pop);
  assign instr       = (count != 2'd0) ? head_ent.dat : '0;
  assign instr_pc    = (count != 2'd0) ? head_ent.pc  : '0;
  assign fifo_count  = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC_ALIGNED;
      count    <= 2'd0;
      head_ent <= '0;
      tail_ent <= '0;
    end else if (redirect_valid) begin
      // Redirect wins over fetch and pop: drop everything buffered.
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      count    <= 2'd0;
      head_ent <= '0;
      tail_ent <= '0;
    end else begin
      if (fetch) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      case ({fetch, pop})
        2'b11: begin
          if (count == 2'd2) begin
            head_ent <= tail_ent;
            tail_ent <= new_ent;
          end else begin
            head_ent <= new_ent;
          end
        end
        2'b10: begin
          if (count == 2'd0) begin
            head_ent <= new_ent;
          end else begin
            tail_ent <= new_ent;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_ent <= tail_ent;
          count    <= count - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
